lfsr_decrypt_engine: RTL

//  Hardware decrypter: inverse of the LFSR encryption program run on the core. On Start it reads
//  MSG_LEN ciphertext bytes from data memory at SRC_BASE, recovers the seed, then identifies the
//  tap pattern from the space-filled preamble, and writes plaintext to DST_BASE.

---
 rtl/lfsr_decrypt_engine.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_decrypt_engine.sv
// LFSR stream decrypter. It recovers the seed from the first ciphertext
// byte, then searches the tap table for the pattern that turns the preamble
// back into spaces. Once a tap matches, it decodes the whole message into
// the destination buffer. The design is a single-port master on a memory
// with combinational read.
module lfsr_decrypt_engine #(
    parameter int SRC_BASE = 64,
    parameter int DST_BASE = 0,
    parameter int MSG_LEN  = 64,
    parameter int PRE_LEN  = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic       Err,
    output logic [7:0] MemAddr,
    output logic       MemWrEn,
    output logic [7:0] MemWrData,
    input  logic [7:0] MemRdData,
    output logic [3:0] TapFound,
    output logic [6:0] SeedFound
);

    localparam logic [7:0] SRC_A    = 8'(SRC_BASE);
    localparam logic [7:0] DST_A    = 8'(DST_BASE);
    localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
    localparam logic [7:0] MSG_LAST = 8'(MSG_LEN - 1);
    localparam logic [6:0] SPACE    = 7'h20;
    localparam logic [3:0] LAST_TAP = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_SEARCH,
        S_NEXT_TAP,
        S_DECODE_RD,
        S_DECODE_WR,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;     // tap index under test / in use
    logic [7:0] i_q, i_d;         // byte index within the message
    logic [6:0] s_q, s_d;         // keystream value for byte i
    logic [6:0] seed_q, seed_d;
    logic [6:0] byte_q, byte_d;   // decoded byte waiting to be written
    logic       err_q, err_d;
    logic [3:0] tap_q, tap_d;
    logic       start_q;
    logic       start_rise;
    logic [6:0] rd_plain;
    logic       rd_unused;

    // Tap table, searched in index order.
    function automatic logic [6:0] tap_of(input logic [3:0] idx);
        case (idx)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            default: tap_of = 7'h7B;
        endcase
    endfunction

    // One keystream step: shift left, feedback is parity of tapped bits.
    function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] tap);
        lfsr_next = {s[5:0], ^(s & tap)};
    endfunction

    // Ciphertext bit 7 carries nothing; only the low seven bits are used.
    assign rd_unused  = MemRdData[7];
    assign rd_plain   = MemRdData[6:0] ^ s_q;
    assign start_rise = Start & ~start_q;

    assign Ack       = (state_q == S_DONE);
    assign Err       = err_q;
    assign TapFound  = tap_q;
    assign SeedFound = seed_q;

    // Next-state, register updates and memory bus drive for the current state.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        i_d       = i_q;
        s_d       = s_q;
        seed_d    = seed_q;
        byte_d    = byte_q;
        err_d     = err_q;
        tap_d     = tap_q;
        MemAddr   = 8'h00;
        MemWrEn   = 1'b0;
        MemWrData = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_SEED;
                    err_d   = 1'b0;
                    tap_d   = 4'd0;
                end
            end

            S_SEED: begin
                // Plaintext byte 0 is a space, so c[0] ^ space is the seed.
                MemAddr = SRC_A;
                seed_d  = MemRdData[6:0] ^ SPACE;
                s_d     = lfsr_next(MemRdData[6:0] ^ SPACE, tap_of(4'd0));
                idx_d   = 4'd0;
                i_d     = 8'd1;
                state_d = S_SEARCH;
            end

            S_SEARCH: begin
                MemAddr = SRC_A + i_q;
                if (rd_plain == SPACE) begin
                    if (i_q == PRE_LAST) begin
                        tap_d   = idx_q;
                        i_d     = 8'd0;
                        s_d     = seed_q;
                        state_d = S_DECODE_RD;
                    end else begin
                        i_d = i_q + 8'd1;
                        s_d = lfsr_next(s_q, tap_of(idx_q));
                    end
                end else begin
                    state_d = S_NEXT_TAP;
                end
            end

            S_NEXT_TAP: begin
                if (idx_q == LAST_TAP) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    i_d     = 8'd1;
                    s_d     = lfsr_next(seed_q, tap_of(idx_q + 4'd1));
                    state_d = S_SEARCH;
                end
            end

            S_DECODE_RD: begin
                MemAddr = SRC_A + i_q;
                byte_d  = rd_plain;
                state_d = S_DECODE_WR;
            end

            S_DECODE_WR: begin
                MemAddr   = DST_A + i_q;
                MemWrEn   = 1'b1;
                MemWrData = {1'b0, byte_q};
                s_d       = lfsr_next(s_q, tap_of(idx_q));
                if (i_q == MSG_LAST) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    state_d = S_DECODE_RD;
                end
            end

            S_DONE: begin
                // Only a fresh rising edge restarts; a held level does not loop.
                if (start_rise) begin
                    state_d = S_SEED;
                    err_d   = 1'b0;
                    tap_d   = 4'd0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Registers: control and visible results are reset, work registers are not.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            tap_q   <= 4'd0;
            seed_q  <= 7'd0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            tap_q   <= tap_d;
            seed_q  <= seed_d;
            start_q <= Start;
        end
        idx_q  <= idx_d;
        i_q    <= i_d;
        s_q    <= s_d;
        byte_q <= byte_d;
    end

endmodule
